// File: rtl/decoder_leaf_router.sv
// rtl/decoder_leaf_router.sv - select-steered flit router with per-output FIFOs and drop counting
module decoder_leaf_router #(
    parameter int W        = 9,
    parameter int NUM_OUT  = 2,
    parameter int DEPTH    = 2,
    parameter int PKT_MODE = 0,
    parameter int SEL_W    = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [W-1:0]         in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 sel_valid,
    output logic                 sel_ready,
    output logic [NUM_OUT*W-1:0] out_data,
    output logic [NUM_OUT-1:0]   out_valid,
    input  logic [NUM_OUT-1:0]   out_ready,
    output logic [15:0]          drop_count,
    output logic                 busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [SEL_W:0] NUM_OUT_C = (SEL_W+1)'(NUM_OUT);

    typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_t;

    state_t             state_q;
    logic [SEL_W-1:0]   cur_q;
    logic [15:0]        drop_q;
    logic               sel_ready_q;
    logic               busy_q;
    logic [NUM_OUT-1:0] full;
    logic               in_hs;
    logic               last_flit;

    assign in_ready   = ((state_q == ROUTE) && !full[cur_q]) || (state_q == DROP);
    assign in_hs      = in_valid && in_ready;
    assign last_flit  = (PKT_MODE == 0) || in_data[W-1];
    assign sel_ready  = sel_ready_q;
    assign busy       = busy_q;
    assign drop_count = drop_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            drop_q      <= '0;
            sel_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sel_valid) begin
                        cur_q       <= sel;
                        state_q     <= ({1'b0, sel} < NUM_OUT_C) ? ROUTE : DROP;
                        sel_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                ROUTE, DROP: begin
                    if (in_hs) begin
                        if (state_q == DROP && drop_q != 16'hFFFF)
                            drop_q <= drop_q + 16'd1;
                        if (last_flit) begin
                            state_q     <= IDLE;
                            sel_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    sel_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_fifo
        logic [W-1:0]  mem_q [DEPTH];
        logic [PW-1:0] wptr_q;
        logic [PW-1:0] rptr_q;
        logic [CW-1:0] cnt_q;
        logic [W-1:0]  head_q;
        logic          push;
        logic          pop;

        assign push = in_hs && (state_q == ROUTE) && (cur_q == SEL_W'(g));
        assign pop  = (cnt_q != '0) && out_ready[g];

        assign full[g]           = (cnt_q == DEPTH_C);
        assign out_valid[g]      = (cnt_q != '0);
        assign out_data[g*W +: W] = head_q;

        always_ff @(posedge CLK) begin
            if (push)
                mem_q[wptr_q] <= in_data;
        end

        // head_q mirrors the entry that will be at the read pointer after this edge
        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
                head_q <= '0;
            end else begin
                if (push)
                    wptr_q <= wptr_q + 1'b1;
                if (pop)
                    rptr_q <= rptr_q + 1'b1;
                if (push && !pop)
                    cnt_q <= cnt_q + ONE_C;
                else if (pop && !push)
                    cnt_q <= cnt_q - ONE_C;
                if (push && ((cnt_q == '0) || (pop && cnt_q == ONE_C)))
                    head_q <= in_data;
                else if (pop && cnt_q > ONE_C)
                    head_q <= mem_q[rptr_q + 1'b1];
            end
        end
    end
endmodule

// File: tb/tb_decoder_leaf_router.sv
// tb/tb_decoder_leaf_router.sv - directed bench for decoder_leaf_router in flit and packet modes
module tb_decoder_leaf_router;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    // a: 2 outputs, one select per flit
    logic [8:0]  a_in_data = '0;
    logic        a_in_valid = 1'b0, a_in_ready;
    logic        a_sel = 1'b0, a_sel_valid = 1'b0, a_sel_ready;
    logic [17:0] a_out_data;
    logic [1:0]  a_out_valid, a_out_ready = '0;
    logic [15:0] a_drop_count;
    logic        a_busy;

    // b: 3 outputs, packet mode
    logic [8:0]  b_in_data = '0;
    logic        b_in_valid = 1'b0, b_in_ready;
    logic [1:0]  b_sel = '0;
    logic        b_sel_valid = 1'b0, b_sel_ready;
    logic [26:0] b_out_data;
    logic [2:0]  b_out_valid, b_out_ready = '0;
    logic [15:0] b_drop_count;
    logic        b_busy;

    decoder_leaf_router #(.W(9), .NUM_OUT(2), .DEPTH(2), .PKT_MODE(0)) dut_a (
        .CLK(clk), .RESET(rst),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .sel(a_sel), .sel_valid(a_sel_valid), .sel_ready(a_sel_ready),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .drop_count(a_drop_count), .busy(a_busy)
    );

    decoder_leaf_router #(.W(9), .NUM_OUT(3), .DEPTH(2), .PKT_MODE(1)) dut_b (
        .CLK(clk), .RESET(rst),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .sel(b_sel), .sel_valid(b_sel_valid), .sel_ready(b_sel_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .drop_count(b_drop_count), .busy(b_busy)
    );

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (2) tick;
        vectors++; if (a_out_valid !== 2'b00) begin miscompares++; $display("FAIL reset_out_valid: got %b want 00", a_out_valid); end
        vectors++; if (a_out_data !== 18'h0) begin miscompares++; $display("FAIL reset_out_data: got %h want 0", a_out_data); end
        vectors++; if (a_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", a_busy); end
        vectors++; if (a_sel_ready !== 1'b1) begin miscompares++; $display("FAIL reset_sel_ready: got %b want 1", a_sel_ready); end
        vectors++; if (a_in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b want 0", a_in_ready); end
        vectors++; if (b_drop_count !== 16'h0) begin miscompares++; $display("FAIL reset_drop: got %h want 0", b_drop_count); end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_flit_mode;
        a_out_ready = 2'b11;
        a_sel = 1'b1; a_sel_valid = 1'b1;
        vectors++; if (a_in_ready !== 1'b0) begin miscompares++; $display("FAIL flit_idle_in_ready: got %b want 0", a_in_ready); end
        tick; a_sel_valid = 1'b0;
        vectors++; if ({a_sel_ready, a_in_ready, a_busy} !== 3'b011) begin miscompares++; $display("FAIL flit_route_hs: got %b want 011", {a_sel_ready, a_in_ready, a_busy}); end
        a_in_data = 9'h0A5; a_in_valid = 1'b1;
        tick; a_in_valid = 1'b0;
        vectors++; if (a_out_valid !== 2'b10) begin miscompares++; $display("FAIL flit_valid1: got %b want 10", a_out_valid); end
        vectors++; if (a_out_data[17:9] !== 9'h0A5) begin miscompares++; $display("FAIL flit_data1: got %h want 0a5", a_out_data[17:9]); end
        vectors++; if ({a_sel_ready, a_in_ready} !== 2'b10) begin miscompares++; $display("FAIL flit_back_idle: got %b want 10", {a_sel_ready, a_in_ready}); end
        a_sel = 1'b0; a_sel_valid = 1'b1;
        tick; a_sel_valid = 1'b0;
        vectors++; if (a_out_valid !== 2'b00) begin miscompares++; $display("FAIL flit_drained: got %b want 00", a_out_valid); end
        a_in_data = 9'h15A; a_in_valid = 1'b1;
        tick; a_in_valid = 1'b0;
        vectors++; if (a_out_valid !== 2'b01) begin miscompares++; $display("FAIL flit_valid0: got %b want 01", a_out_valid); end
        vectors++; if (a_out_data !== {9'h0A5, 9'h15A}) begin miscompares++; $display("FAIL flit_data0_hold1: got %h want %h", a_out_data, {9'h0A5, 9'h15A}); end
        tick;
    endtask

    task automatic test_packet;
        b_out_ready = 3'b111;
        b_sel = 2'd2; b_sel_valid = 1'b1;
        tick; b_sel_valid = 1'b0;
        b_in_data = 9'h001; b_in_valid = 1'b1;
        vectors++; if ({b_sel_ready, b_in_ready} !== 2'b01) begin miscompares++; $display("FAIL pkt_head_ready: got %b want 01", {b_sel_ready, b_in_ready}); end
        tick; b_in_data = 9'h002;
        vectors++; if (b_out_valid !== 3'b100 || b_out_data[26:18] !== 9'h001) begin miscompares++; $display("FAIL pkt_flit1: got %b/%h want 100/001", b_out_valid, b_out_data[26:18]); end
        tick; b_in_data = 9'h103;
        vectors++; if (b_out_data[26:18] !== 9'h002 || b_sel_ready !== 1'b0) begin miscompares++; $display("FAIL pkt_flit2: got %h/%b want 002/0", b_out_data[26:18], b_sel_ready); end
        tick; b_in_valid = 1'b0;
        vectors++; if (b_out_data[26:18] !== 9'h103 || b_sel_ready !== 1'b1) begin miscompares++; $display("FAIL pkt_tail: got %h/%b want 103/1", b_out_data[26:18], b_sel_ready); end
        tick;
        vectors++; if (b_out_valid !== 3'b000) begin miscompares++; $display("FAIL pkt_drained: got %b want 000", b_out_valid); end
    endtask

    task automatic test_stall;
        logic [8:0] sv [3] = '{9'h011, 9'h022, 9'h033};
        a_out_ready = 2'b00;
        for (int k = 0; k < 3; k++) begin
            a_sel = 1'b0; a_sel_valid = 1'b1;
            tick; a_sel_valid = 1'b0;
            a_in_data = sv[k]; a_in_valid = 1'b1;
            if (k < 2) begin
                tick; a_in_valid = 1'b0;
            end
        end
        vectors++; if (a_in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_full: got %b want 0", a_in_ready); end
        tick;
        vectors++; if (a_in_ready !== 1'b0 || a_out_data[8:0] !== 9'h011) begin miscompares++; $display("FAIL stall_hold: got %b/%h want 0/011", a_in_ready, a_out_data[8:0]); end
        a_out_ready = 2'b01;
        vectors++; if (a_in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_no_bypass: got %b want 0", a_in_ready); end
        tick;
        vectors++; if (a_out_data[8:0] !== 9'h022 || a_in_ready !== 1'b1) begin miscompares++; $display("FAIL stall_rel1: got %h/%b want 022/1", a_out_data[8:0], a_in_ready); end
        tick; a_in_valid = 1'b0;
        vectors++; if (a_out_data[8:0] !== 9'h033 || a_out_valid[0] !== 1'b1) begin miscompares++; $display("FAIL stall_rel2: got %h/%b want 033/1", a_out_data[8:0], a_out_valid[0]); end
        tick;
        vectors++; if (a_out_valid !== 2'b00) begin miscompares++; $display("FAIL stall_empty: got %b want 00", a_out_valid); end
    endtask

    task automatic test_drop;
        logic [8:0] dv [4] = '{9'h001, 9'h002, 9'h003, 9'h104};
        b_out_ready = 3'b111;
        b_sel = 2'd3; b_sel_valid = 1'b1;
        tick; b_sel_valid = 1'b0;
        vectors++; if ({b_busy, b_in_ready} !== 2'b11) begin miscompares++; $display("FAIL drop_enter: got %b want 11", {b_busy, b_in_ready}); end
        for (int i = 0; i < 4; i++) begin
            b_in_data = dv[i]; b_in_valid = 1'b1;
            vectors++; if (b_in_ready !== 1'b1 || b_out_valid !== 3'b000) begin miscompares++; $display("FAIL drop_flit%0d: got %b/%b want 1/000", i, b_in_ready, b_out_valid); end
            tick;
        end
        b_in_valid = 1'b0;
        vectors++; if (b_drop_count !== 16'd4) begin miscompares++; $display("FAIL drop_count: got %0d want 4", b_drop_count); end
        vectors++; if ({b_sel_ready, b_busy, b_out_valid} !== 5'b10000) begin miscompares++; $display("FAIL drop_exit: got %b want 10000", {b_sel_ready, b_busy, b_out_valid}); end
    endtask

    task automatic test_mid_reset;
        logic [1:0] ps [3] = '{2'd0, 2'd1, 2'd2};
        logic [8:0] pd [3] = '{9'h1F0, 9'h1F1, 9'h0F2};
        b_out_ready = 3'b000;
        for (int i = 0; i < 3; i++) begin
            b_sel = ps[i]; b_sel_valid = 1'b1;
            tick; b_sel_valid = 1'b0;
            b_in_data = pd[i]; b_in_valid = 1'b1;
            tick; b_in_valid = 1'b0;
        end
        vectors++; if ({b_out_valid, b_busy} !== 4'b1111) begin miscompares++; $display("FAIL mrst_pre: got %b want 1111", {b_out_valid, b_busy}); end
        #2 rst = 1'b1;
        #1;
        vectors++; if ({b_out_valid, b_busy, b_sel_ready, b_in_ready} !== 6'b000010) begin miscompares++; $display("FAIL mrst_async: got %b want 000010", {b_out_valid, b_busy, b_sel_ready, b_in_ready}); end
        vectors++; if (b_drop_count !== 16'd0) begin miscompares++; $display("FAIL mrst_drop: got %0d want 0", b_drop_count); end
        tick; rst = 1'b0;
        b_out_ready = 3'b111;
        b_sel = 2'd1; b_sel_valid = 1'b1;
        tick; b_sel_valid = 1'b0;
        b_in_data = 9'h1B7; b_in_valid = 1'b1;
        tick; b_in_valid = 1'b0;
        vectors++; if (b_out_valid !== 3'b010 || b_out_data[17:9] !== 9'h1B7) begin miscompares++; $display("FAIL mrst_after: got %b/%h want 010/1b7", b_out_valid, b_out_data[17:9]); end
        tick;
    endtask

    task automatic test_isolation;
        logic [8:0] fd [2] = '{9'h1A1, 9'h1A2};
        b_out_ready = 3'b010;
        for (int i = 0; i < 2; i++) begin
            b_sel = 2'd0; b_sel_valid = 1'b1;
            tick; b_sel_valid = 1'b0;
            b_in_data = fd[i]; b_in_valid = 1'b1;
            tick; b_in_valid = 1'b0;
        end
        b_sel = 2'd1; b_sel_valid = 1'b1;
        tick; b_sel_valid = 1'b0;
        b_in_data = 9'h011; b_in_valid = 1'b1;
        vectors++; if (b_in_ready !== 1'b1) begin miscompares++; $display("FAIL iso_ready: got %b want 1", b_in_ready); end
        tick; b_in_data = 9'h112;
        vectors++; if (b_out_data[17:9] !== 9'h011) begin miscompares++; $display("FAIL iso_flit1: got %h want 011", b_out_data[17:9]); end
        tick; b_in_valid = 1'b0;
        vectors++; if (b_out_data[17:9] !== 9'h112 || b_out_valid[1] !== 1'b1) begin miscompares++; $display("FAIL iso_flit2: got %h/%b want 112/1", b_out_data[17:9], b_out_valid[1]); end
        vectors++; if (b_out_data[8:0] !== 9'h1A1 || b_out_valid[0] !== 1'b1) begin miscompares++; $display("FAIL iso_out0_kept: got %h/%b want 1a1/1", b_out_data[8:0], b_out_valid[0]); end
        b_out_ready = 3'b111;
        tick;
        vectors++; if (b_out_data[8:0] !== 9'h1A2 || b_out_valid[0] !== 1'b1) begin miscompares++; $display("FAIL iso_out0_second: got %h/%b want 1a2/1", b_out_data[8:0], b_out_valid[0]); end
        tick;
        vectors++; if (b_out_valid !== 3'b000) begin miscompares++; $display("FAIL iso_drained: got %b want 000", b_out_valid); end
    endtask

    initial begin
        test_reset;
        test_flit_mode;
        test_packet;
        test_stall;
        test_drop;
        test_mid_reset;
        test_isolation;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end
endmodule
